// File: rtl/imm_narrow_pipe_if.sv
// Valid/ready bus for the immediate narrowing pipe.
// master drives beats in and takes them out; slave is the pipe itself.
interface imm_narrow_pipe_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 12,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_value;
  logic             in_signed;
  logic             in_sat;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic             out_fits;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_value, in_signed, in_sat, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fits, out_tag
  );

  modport slave (
    input  in_valid, in_value, in_signed, in_sat, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fits, out_tag
  );
endinterface

// File: rtl/imm_narrow_pipe.sv
// Two-stage immediate narrowing pipe: S1 holds the fit decision, S2 holds
// the final immediate. Saturating miss counter counts non-fitting beats.
module imm_narrow_pipe #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 12,
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_narrow_pipe_if.slave bus,
  input  logic             clear_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX = '1;

  // S1 keeps only what S2 needs: the low field, the sign bit and the mode
  logic             r_s1_vld;
  logic [OUT_W-1:0] r_s1_low;
  logic             r_s1_msb;
  logic             r_s1_sgn;
  logic             r_s1_sat;
  logic             r_s1_fits;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_vld;
  logic [OUT_W-1:0] r_s2_imm;
  logic             r_s2_fits;
  logic [TAG_W-1:0] r_s2_tag;

  logic [CNT_W-1:0] r_cnt;

  logic             w_fit;
  logic [OUT_W-1:0] w_imm;
  logic             w_s1_load;
  logic             w_s1_move;
  logic             w_s2_move;

  // stage advance: ready ripples back combinationally from out_ready
  assign w_s2_move = r_s2_vld & bus.out_ready;
  assign w_s1_move = r_s1_vld & (~r_s2_vld | bus.out_ready);
  assign bus.in_ready = ~r_s1_vld | w_s1_move;
  assign w_s1_load = bus.in_valid & bus.in_ready;

  assign bus.out_valid = r_s2_vld;
  assign bus.out_imm   = r_s2_imm;
  assign bus.out_fits  = r_s2_fits;
  assign bus.out_tag   = r_s2_tag;
  assign miss_count    = r_cnt;

  // fit check: signed needs bits above the field's sign bit to copy it,
  // unsigned needs everything above the field to be zero
  always_comb begin
    w_fit = 1'b0;
    if (bus.in_signed)
      w_fit = (&bus.in_value[IN_W-1:OUT_W-1]) | ~(|bus.in_value[IN_W-1:OUT_W-1]);
    else
      w_fit = ~(|bus.in_value[IN_W-1:OUT_W]);
  end

  // final immediate: truncate unless out of range and clamping requested
  always_comb begin
    w_imm = r_s1_low;
    if (!r_s1_fits && r_s1_sat)
      w_imm = r_s1_sgn ? (r_s1_msb ? SMIN : SMAX) : UMAX;
  end

  // S1 register: load a new beat when empty or draining
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_low  <= '0;
      r_s1_msb  <= 1'b0;
      r_s1_sgn  <= 1'b0;
      r_s1_sat  <= 1'b0;
      r_s1_fits <= 1'b0;
      r_s1_tag  <= '0;
    end else if (w_s1_load) begin
      r_s1_vld  <= 1'b1;
      r_s1_low  <= bus.in_value[OUT_W-1:0];
      r_s1_msb  <= bus.in_value[IN_W-1];
      r_s1_sgn  <= bus.in_signed;
      r_s1_sat  <= bus.in_sat;
      r_s1_fits <= w_fit;
      r_s1_tag  <= bus.in_tag;
    end else if (w_s1_move) begin
      r_s1_vld  <= 1'b0;
    end
  end

  // S2 register: outputs come straight from here, held while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_imm  <= '0;
      r_s2_fits <= 1'b0;
      r_s2_tag  <= '0;
    end else if (w_s1_move) begin
      r_s2_vld  <= 1'b1;
      r_s2_imm  <= w_imm;
      r_s2_fits <= r_s1_fits;
      r_s2_tag  <= r_s1_tag;
    end else if (w_s2_move) begin
      r_s2_vld  <= 1'b0;
    end
  end

  // miss counter: clear has priority, increment sticks at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (clear_count)
      r_cnt <= '0;
    else if (w_s2_move && !r_s2_fits && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: tb/tb_imm_narrow_pipe.sv
// Directed bench for imm_narrow_pipe (miss counter built 4 bits wide).
module tb_imm_narrow_pipe;
  localparam int IN_W = 64, OUT_W = 12, TAG_W = 6, CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear_count;
  logic [CNT_W-1:0] miss_count;
  int               checks = 0;
  int               errors = 0;

  imm_narrow_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_narrow_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .clear_count(clear_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] v, input logic s, input logic sat, input logic [5:0] t);
    bus.in_valid = 1'b1; bus.in_value = v; bus.in_signed = s; bus.in_sat = sat; bus.in_tag = t;
  endtask

  // one isolated beat: present, capture into S1, capture into S2, check
  task automatic one(input string tag, input logic [63:0] v, input logic s, input logic sat,
                     input logic [11:0] eimm, input logic efit);
    drive(v, s, sat, 6'h15);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk({tag, "_vld"}, bus.out_valid, 1);
    chk({tag, "_imm"}, bus.out_imm, eimm);
    chk({tag, "_fit"}, bus.out_fits, efit);
    chk({tag, "_tag"}, bus.out_tag, 6'h15);
  endtask

  initial begin
    logic [31:0] pat;
    int occ, nxt, exp_t;
    logic stall;
    logic [11:0] s_imm;
    logic [5:0] s_tag;
    bit in_hs, out_hs;

    reset_n = 1'b0; clear_count = 1'b0;
    bus.in_valid = 1'b0; bus.in_value = '0; bus.in_signed = 1'b0; bus.in_sat = 1'b0;
    bus.in_tag = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_ovld", bus.out_valid, 0);
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_fits", bus.out_fits, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_miss", miss_count, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_iready", bus.in_ready, 1);

    // signed clamp
    one("sat_pos", 64'd14736, 1, 1, 12'h7FF, 0);
    one("sat_neg", -64'd14736, 1, 1, 12'h800, 0);
    one("sat_zero", 64'd0, 1, 1, 12'h000, 1);
    tick();
    chk("miss_2", miss_count, 2);

    // boundaries, truncating
    one("s_2047", 64'd2047, 1, 0, 12'h7FF, 1);
    one("s_2048", 64'd2048, 1, 0, 12'h800, 0);
    one("s_m2048", -64'd2048, 1, 0, 12'h800, 1);
    one("u_2048", 64'd2048, 0, 0, 12'h800, 1);
    one("u_m1", -64'd1, 0, 0, 12'hFFF, 0);
    one("s_m1", -64'd1, 1, 0, 12'hFFF, 1);
    one("u_sat", 64'h1000, 0, 1, 12'hFFF, 0);
    tick();
    chk("miss_5", miss_count, 5);

    // backpressure stream of tags 0..9
    pat = 32'hB3A5_6C9D; occ = 0; nxt = 0; exp_t = 0; stall = 0; s_imm = '0; s_tag = '0;
    for (int c = 0; c < 200 && exp_t < 10; c++) begin
      bus.in_valid = (nxt < 10);
      bus.in_value = 64'(nxt * 3); bus.in_signed = 1'b1; bus.in_sat = 1'b0;
      bus.in_tag = 6'(nxt);
      bus.out_ready = pat[c % 32];
      #1;
      chk("bp_iready", bus.in_ready, !(occ == 2 && !bus.out_ready));
      if (stall) begin
        chk("bp_hold_vld", bus.out_valid, 1);
        chk("bp_hold_imm", bus.out_imm, s_imm);
        chk("bp_hold_tag", bus.out_tag, s_tag);
      end
      in_hs  = bus.in_valid && bus.in_ready;
      out_hs = bus.out_valid && bus.out_ready;
      if (out_hs) begin
        chk("bp_tag", bus.out_tag, 6'(exp_t));
        chk("bp_imm", bus.out_imm, 12'(exp_t * 3));
        exp_t++;
      end
      stall = bus.out_valid && !bus.out_ready;
      s_imm = bus.out_imm; s_tag = bus.out_tag;
      occ = occ + int'(in_hs) - int'(out_hs);
      if (in_hs) nxt++;
      tick();
    end
    chk("bp_count", exp_t, 10);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("bp_empty", bus.out_valid, 0);

    // saturation of the 4-bit counter
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    chk("clr", miss_count, 0);
    drive(64'h1000, 1, 0, 6'h3);
    repeat (20) tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("miss_sat", miss_count, 15);

    // clear beats a simultaneous miss handshake
    drive(64'h1000, 1, 0, 6'h4);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("clrhs_vld", bus.out_valid, 1);
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    chk("clrhs_miss", miss_count, 0);
    tick();
    chk("clrhs_hold", miss_count, 0);

    // reset with two beats in flight
    one("pre_rst", 64'h1000, 1, 0, 12'h000, 0);
    tick();
    chk("pre_rst_miss", miss_count, 1);
    bus.out_ready = 1'b0;
    drive(64'h7777, 1, 0, 6'h8);
    tick();
    drive(64'h8888, 1, 0, 6'h9);
    tick();
    bus.in_valid = 1'b0;
    chk("inflight_full", bus.in_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_vld", bus.out_valid, 0);
    chk("arst_miss", miss_count, 0);
    tick();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(64'd5, 1, 0, 6'h2A);
    tick();
    bus.in_valid = 1'b0;
    chk("post_no_stale", bus.out_valid, 0);
    tick();
    chk("post_vld", bus.out_valid, 1);
    chk("post_tag", bus.out_tag, 6'h2A);
    chk("post_imm", bus.out_imm, 12'h005);
    tick();
    chk("post_empty", bus.out_valid, 0);
    chk("post_miss", miss_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
